// File: rtl/sr_flag_pkg.sv
// Shared constants for the set/reset flag bank: both-asserted response modes
// and the {set,clear} pair encoding.
package sr_flag_pkg;

  localparam int MODE_RDOM   = 0;
  localparam int MODE_SDOM   = 1;
  localparam int MODE_TOGGLE = 2;

  localparam logic [1:0] PAIR_HOLD = 2'b00;
  localparam logic [1:0] PAIR_SET  = 2'b10;
  localparam logic [1:0] PAIR_CLR  = 2'b01;
  localparam logic [1:0] PAIR_BOTH = 2'b11;

endpackage

// File: rtl/sr_flag_chan.sv
// One flag channel: glitch filter on the {set,clear} pair, the flag itself,
// its change pulse and its sticky event bit.
module sr_flag_chan
  import sr_flag_pkg::*;
#(
  parameter int   FILT = 3,
  parameter int   MODE = MODE_RDOM,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clear,
  input  logic clr_evt,
  output logic q,
  output logic chg,
  output logic evt
);

  localparam int            CW      = $clog2(FILT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT);

  logic [1:0]    pair;
  logic [1:0]    prev_pair;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          fire;
  logic          q_n;
  logic          q_changes;

  assign pair = {set, clear};

  // The counter saturates at FILT, so a pair held indefinitely fires only once.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_n = cnt;
    fire  = 1'b0;
    if (pair != prev_pair) begin
      cnt_n = CW'(1);
      fire  = (FILT == 1);
    end else if (cnt < CNT_MAX) begin
      cnt_n = cnt + 1'b1;
      fire  = (cnt_n == CNT_MAX);
    end
  end

  always_comb begin
    q_n = q;
    if (fire) begin
      case (pair)
        PAIR_SET:  q_n = 1'b1;
        PAIR_CLR:  q_n = 1'b0;
        PAIR_BOTH: begin
          if (MODE == MODE_SDOM)        q_n = 1'b1;
          else if (MODE == MODE_TOGGLE) q_n = ~q;
          else                          q_n = 1'b0;
        end
        default:   q_n = q;
      endcase
    end
  end

  assign q_changes = q_n ^ q;

  // evt rises together with chg, and a clear arriving while chg is still
  // high loses to it, so no change can slip past software unseen.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= INIT;
      chg       <= 1'b0;
      evt       <= 1'b0;
      prev_pair <= PAIR_HOLD;
      cnt       <= CNT_MAX;
    end else begin
      q         <= q_n;
      chg       <= q_changes;
      evt       <= q_changes | chg | (evt & ~clr_evt);
      prev_pair <= pair;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of CH independent filtered set/reset flags with change pulses,
// sticky event bits and an interrupt summary.
module sr_flag_bank
  import sr_flag_pkg::*;
#(
  parameter int          CH   = 8,
  parameter int          FILT = 3,
  parameter int          MODE = MODE_RDOM,
  parameter logic [CH-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] set,
  input  logic [CH-1:0] clear,
  input  logic [CH-1:0] clr_evt,
  output logic [CH-1:0] q,
  output logic [CH-1:0] qbar,
  output logic [CH-1:0] chg,
  output logic [CH-1:0] evt,
  output logic          irq
);

  if (CH < 1 || FILT < 1 || MODE < MODE_RDOM || MODE > MODE_TOGGLE) begin : g_bad_param
    $fatal(1, "sr_flag_bank: illegal parameters CH=%0d FILT=%0d MODE=%0d", CH, FILT, MODE);
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    sr_flag_chan #(
      .FILT (FILT),
      .MODE (MODE),
      .INIT (INIT[i])
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .set     (set[i]),
      .clear   (clear[i]),
      .clr_evt (clr_evt[i]),
      .q       (q[i]),
      .chg     (chg[i]),
      .evt     (evt[i])
    );
  end

  assign qbar = ~q;
  assign irq  = |evt;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Self-checking bench: four bank variants share one stimulus stream and are
// compared each cycle against a run-length reference model.
module tb_sr_flag_bank;

  localparam int NI = 4;
  localparam int CH = 8;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] set, clear, clr_evt;

  logic [NI-1:0][CH-1:0] q_o, qbar_o, chg_o, evt_o;
  logic [NI-1:0]         irq_o;

  // Variant 0: FILT3 MODE0 INIT A5, 1: FILT3 MODE1, 2: FILT3 MODE2, 3: FILT1 MODE0
  int          p_filt [NI] = '{3, 3, 3, 1};
  int          p_mode [NI] = '{0, 1, 2, 0};
  logic [7:0]  p_init [NI] = '{8'hA5, 8'h00, 8'h00, 8'h00};

  sr_flag_bank #(.CH(CH), .FILT(3), .MODE(0), .INIT(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .set(set), .clear(clear), .clr_evt(clr_evt),
    .q(q_o[0]), .qbar(qbar_o[0]), .chg(chg_o[0]), .evt(evt_o[0]), .irq(irq_o[0]));
  sr_flag_bank #(.CH(CH), .FILT(3), .MODE(1), .INIT(8'h00)) dut1 (
    .clk(clk), .rst(rst), .set(set), .clear(clear), .clr_evt(clr_evt),
    .q(q_o[1]), .qbar(qbar_o[1]), .chg(chg_o[1]), .evt(evt_o[1]), .irq(irq_o[1]));
  sr_flag_bank #(.CH(CH), .FILT(3), .MODE(2), .INIT(8'h00)) dut2 (
    .clk(clk), .rst(rst), .set(set), .clear(clear), .clr_evt(clr_evt),
    .q(q_o[2]), .qbar(qbar_o[2]), .chg(chg_o[2]), .evt(evt_o[2]), .irq(irq_o[2]));
  sr_flag_bank #(.CH(CH), .FILT(1), .MODE(0), .INIT(8'h00)) dut3 (
    .clk(clk), .rst(rst), .set(set), .clear(clear), .clr_evt(clr_evt),
    .q(q_o[3]), .qbar(qbar_o[3]), .chg(chg_o[3]), .evt(evt_o[3]), .irq(irq_o[3]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: length of the current run of identical pairs; a command
  // takes effect on the sample where the run length reaches exactly FILT.
  logic [1:0] m_last [NI][CH];
  int         m_run  [NI][CH];
  bit         m_q    [NI][CH];
  bit         m_chg  [NI][CH];
  bit         m_evt  [NI][CH];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < CH; i++) begin
        logic [1:0] p;
        bit nq, nchg;
        p = {set[i], clear[i]};
        if (rst) begin
          m_q[k][i]    = p_init[k][i];
          m_chg[k][i]  = 1'b0;
          m_evt[k][i]  = 1'b0;
          m_last[k][i] = 2'b00;
          m_run[k][i]  = p_filt[k];
        end else begin
          if (p != m_last[k][i]) begin
            m_last[k][i] = p;
            m_run[k][i]  = 1;
          end else if (m_run[k][i] < 1000) begin
            m_run[k][i]++;
          end
          nq = m_q[k][i];
          if (m_run[k][i] == p_filt[k]) begin
            if (p == 2'b10) nq = 1'b1;
            else if (p == 2'b01) nq = 1'b0;
            else if (p == 2'b11) nq = (p_mode[k] == 1) ? 1'b1 :
                                      (p_mode[k] == 2) ? ~m_q[k][i] : 1'b0;
          end
          nchg = (nq != m_q[k][i]);
          m_evt[k][i] = nchg | m_chg[k][i] | (m_evt[k][i] & ~clr_evt[i]);
          m_chg[k][i] = nchg;
          m_q[k][i]   = nq;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic [7:0] eq, ec, ee;
      for (int i = 0; i < CH; i++) begin
        eq[i] = m_q[k][i];
        ec[i] = m_chg[k][i];
        ee[i] = m_evt[k][i];
      end
      check($sformatf("dut%0d.q", k),    q_o[k],    eq);
      check($sformatf("dut%0d.qbar", k), qbar_o[k], ~eq);
      check($sformatf("dut%0d.chg", k),  chg_o[k],  ec);
      check($sformatf("dut%0d.evt", k),  evt_o[k],  ee);
      check($sformatf("dut%0d.irq", k),  {7'b0, irq_o[k]}, {7'b0, |ee});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  int pulses_b, pulses_c;

  initial begin
    rst = 1'b1; set = 8'hFF; clear = 8'($urandom); clr_evt = 8'h00;
    tick(); tick();
    check("reset.q",    q_o[0],    8'hA5);
    check("reset.qbar", qbar_o[0], 8'h5A);
    check("reset.chg",  chg_o[0],  8'h00);
    check("reset.evt",  evt_o[0],  8'h00);
    check("reset.irq",  {7'b0, irq_o[0]}, 8'h00);
    rst = 1'b0; set = 8'h00; clear = 8'h00;
    repeat (3) tick();

    // Two-cycle glitch then a genuine three-cycle set on ch0
    set = 8'h01; tick(); tick();
    set = 8'h00; tick();
    check("glitch.q0",  {7'b0, q_o[1][0]}, 8'h00);
    check("glitch.chg", chg_o[1], 8'h00);
    tick();
    set = 8'h01; tick(); tick(); tick();
    check("filt.q0",   {7'b0, q_o[1][0]},   8'h01);
    check("filt.chg0", {7'b0, chg_o[1][0]}, 8'h01);
    check("filt.evt0", {7'b0, evt_o[1][0]}, 8'h01);
    check("filt.irq",  {7'b0, irq_o[1]},    8'h01);
    set = 8'h00; tick();
    check("filt.chg0_drop", {7'b0, chg_o[1][0]}, 8'h00);

    // ch1: set, then hold both asserted for 10 cycles
    set = 8'h02; repeat (3) tick();
    set = 8'h00; repeat (2) tick();
    set = 8'h02; clear = 8'h02;
    pulses_b = 0; pulses_c = 0;
    repeat (10) begin
      tick();
      pulses_b += int'(chg_o[1][1]);
      pulses_c += int'(chg_o[2][1]);
    end
    check("both.mode0_q1", {7'b0, q_o[0][1]}, 8'h00);
    check("both.mode1_q1", {7'b0, q_o[1][1]}, 8'h01);
    check("both.mode2_q1", {7'b0, q_o[2][1]}, 8'h00);
    check("both.mode1_pulses", 8'(pulses_b), 8'd0);
    check("both.mode2_pulses", 8'(pulses_c), 8'd1);
    set = 8'h00; clear = 8'h00; repeat (2) tick();

    // ch2 event clear colliding with a new change
    clr_evt = 8'hFF; tick();
    clr_evt = 8'h00; repeat (2) tick();
    set = 8'h04; repeat (3) tick();
    check("evt.set2", {7'b0, evt_o[1][2]}, 8'h01);
    set = 8'h00; repeat (2) tick();
    clear = 8'h04; tick(); tick();
    clr_evt = 8'h04; tick();
    check("evt.chg2", {7'b0, chg_o[1][2]}, 8'h01);
    tick();
    check("evt.collide", {7'b0, evt_o[1][2]}, 8'h01);
    clr_evt = 8'h00; clear = 8'h00; tick();
    clr_evt = 8'h04; tick();
    clr_evt = 8'h00;
    check("evt.cleared", {7'b0, evt_o[1][2]}, 8'h00);
    check("evt.irq0",    {7'b0, irq_o[1]},    8'h00);

    // Reset in the middle of a filter run on ch3
    set = 8'h08; tick(); tick();
    rst = 1'b1; tick();
    check("rstmid.q_init", q_o[0], 8'hA5);
    check("rstmid.q3",     {7'b0, q_o[1][3]}, 8'h00);
    rst = 1'b0; tick(); tick();
    check("rstmid.q3_wait", {7'b0, q_o[1][3]}, 8'h00);
    tick();
    check("rstmid.q3_rise", {7'b0, q_o[1][3]}, 8'h01);
    set = 8'h00; repeat (2) tick();

    // Concurrent set on ch0 and clear on ch5 (FILT=1 variant)
    set = 8'h20; tick();
    set = 8'h00; tick();
    clear = 8'h01; tick();
    clear = 8'h00; repeat (2) tick();
    clr_evt = 8'hFF; tick();
    clr_evt = 8'h00; tick();
    set = 8'h01; clear = 8'h20; tick();
    check("conc.q",   q_o[3],   8'h09);
    check("conc.chg", chg_o[3], 8'h21);
    check("conc.evt", evt_o[3], 8'h21);
    set = 8'h00; clear = 8'h00; repeat (2) tick();

    // Randomized runs of held pairs with sporadic resets and event clears
    repeat (80) begin
      int hold;
      set   = 8'($urandom);
      clear = 8'($urandom);
      hold  = $urandom_range(1, 5);
      repeat (hold) begin
        clr_evt = 8'($urandom & $urandom & $urandom);
        rst     = ($urandom_range(0, 40) == 0);
        tick();
      end
    end
    rst = 1'b0; clr_evt = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
